cache_miss_ctrl: RTL
====================

// Module: cache_miss_ctrl
// PURPOSE
//  Core-side controller for the direct-mapped, word-line cache: tag/valid lookup, miss refill from main memory.
//  Write-through to main memory. Sits between core load/store unit and main-memory port.
//  Owns the data array, tag array, valid bits and hit/miss performance counters.
//  Addressing is word-granular: index = addr[INDEX_W-1:0], tag = addr[ADDR_W-1:INDEX_W].
// PARAMETERS
//  ADDR_W   32  address width (word address)
//  DATA_W   32  data word width
//  INDEX_W  7   index bits; 2**INDEX_W lines, TAG_W = ADDR_W-INDEX_W
//  CNT_W    16  width of hit/miss counters
// PORTS
//  clk         in   1        clock, all state on posedge
//  rst_n       in   1        async active-low reset
//  core_req    in   1        request; level, held by core until core_ready
//  core_we     in   1        1=store, 0=load; valid with core_req
//  core_addr   in   ADDR_W   word address; valid with core_req
//  core_wdata  in   DATA_W   store data
//  core_rdata  out  DATA_W   load data; valid when core_ready & load
//  core_ready  out  1        1-cycle completion pulse
//  flush       in   1        invalidate all lines (1-cycle pulse)
//  mem_req     out  1        memory request, held until mem_ack
//  mem_we      out  1        memory write strobe, stable while mem_req
//  mem_addr    out  ADDR_W   memory address, stable while mem_req
//  mem_wdata   out  DATA_W   memory write data
//  mem_rdata   in   DATA_W   memory read data, valid with mem_ack on a read
//  mem_ack     in   1        memory completion, 1 cycle
//  hit_cnt     out  CNT_W    load hits, saturating
//  miss_cnt    out  CNT_W    load misses, saturating
// BEHAVIOUR
//  Reset: state=IDLE, all valid bits=0, core_ready=0, core_rdata=0, mem_req=0, mem_we=0, mem_addr=0,
//   mem_wdata=0, hit_cnt=0, miss_cnt=0. Data/tag arrays not reset.
//  Reset mid-operation aborts the transaction; mem_req drops asynchronously.
//  FSM states: IDLE, REFILL, WTHRU, RESP.
//  IDLE: request accepted on posedge when core_req=1 and flush=0; addr/we/wdata captured.
//   load hit (valid[idx] & tag match) -> RESP; core_rdata<=data[idx]; hit_cnt++.
//   load miss -> REFILL; mem_req=1, mem_we=0, mem_addr=addr; miss_cnt++.
//   store -> WTHRU; data[idx]<=wdata, tag[idx]<=tag, valid[idx]<=1 (write-allocate, hit or miss);
//    mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata.
//  REFILL: wait mem_ack. On ack: data[idx]<=mem_rdata, tag, valid<=1, core_rdata<=mem_rdata,
//   mem_req<=0 -> RESP.
//  WTHRU: wait mem_ack. On ack: mem_req<=0, mem_we<=0 -> RESP.
//  RESP: core_ready=1 for exactly one cycle -> IDLE. Core drops or changes core_req after core_ready.
//  Latency: load hit = core_ready 1 cycle after acceptance edge;
//   miss/store = 1 cycle after the mem_ack edge.
//  flush: honoured only in IDLE; clears all valid bits in one cycle.
//   flush & core_req same cycle: flush wins, request not accepted (stays pending, taken next cycle).
//   flush outside IDLE: ignored.
//  mem_ack while mem_req=0: ignored. mem_ack in the same cycle as mem_req rise is legal (next-edge completion).
//  Counters saturate at 2**CNT_W-1; stores update neither counter. flush does not clear counters.
//  core_rdata holds its last value until the next load completes.
// STRUCTURE
//  Package cache_pkg: state enum (IDLE/REFILL/WTHRU/RESP), localparams TAG_W and LINES.
//  Sub-module cache_tag_ram: tag+valid storage with combinational hit output and one-cycle flush clear.
//  Data array and FSM live in cache_miss_ctrl.
// TESTING
//  Cold load 0x0000_0085 -> REFILL, mem_addr=0x85; ack with 0xDEAD_BEEF -> core_ready, rdata=0xDEADBEEF, miss_cnt=1.
//  Repeat load 0x85 -> core_ready 1 cycle later, rdata=0xDEADBEEF, no mem_req, hit_cnt=1.
//  Load 0x105 (same index 0x05, new tag) -> miss refill, line replaced; reload 0x85 -> miss again, miss_cnt=3.
//  Store 0x10 data 0x1234 -> mem_req/mem_we=1, wdata=0x1234 until ack (delay 5 cycles); then load 0x10 -> hit 0x1234.
//  flush together with core_req -> all lines invalid, request taken next cycle; load 0x10 -> miss.
//  Assert rst_n during REFILL -> mem_req=0 immediately, counters 0, all lines invalid after release.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped word-line cache.
// The controller derives its own geometry from its parameters.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WTHRU,
        RESP
    } state_e;

    localparam int ADDR_W_DEF  = 32;
    localparam int INDEX_W_DEF = 7;
    localparam int TAG_W       = ADDR_W_DEF - INDEX_W_DEF;
    localparam int LINES       = 2 ** INDEX_W_DEF;

endpackage

// File: rtl/cache_tag_ram.sv
// Tag and valid storage with a combinational hit output.
// Valid bits reset and flush-clear in one cycle; tags are never reset.
module cache_tag_ram #(
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               hit,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               flush
);

    localparam int NL = 2 ** INDEX_W;

    logic [TAG_W-1:0] tags [NL];
    logic [NL-1:0]    valid;

    assign hit = valid[rd_idx] && (tags[rd_idx] == rd_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Direct-mapped write-through cache controller: lookup, refill, write-through
// and saturating load hit/miss counters.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TW = ADDR_W - INDEX_W;
    localparam int NL = 2 ** INDEX_W;

    state_e state, state_nx;

    logic [DATA_W-1:0]  data_mem [NL];
    logic [INDEX_W-1:0] core_idx, fill_idx, wr_idx;
    logic [TW-1:0]      core_tag, fill_tag, wr_tag;
    logic               hit;
    logic               accept, load_hit, load_miss, store;
    logic               fill_done, wt_done, flush_en, tag_wr;

    assign core_idx = core_addr[INDEX_W-1:0];
    assign core_tag = core_addr[ADDR_W-1:INDEX_W];
    assign fill_idx = mem_addr[INDEX_W-1:0];
    assign fill_tag = mem_addr[ADDR_W-1:INDEX_W];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (load_hit) begin
                    state_nx = RESP;
                end else if (load_miss) begin
                    state_nx = REFILL;
                end else if (store) begin
                    state_nx = WTHRU;
                end
            end
            REFILL: if (mem_ack) state_nx = RESP;
            WTHRU:  if (mem_ack) state_nx = RESP;
            RESP:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // outputs and control strobes
    always_comb begin
        accept     = 1'b0;
        load_hit   = 1'b0;
        load_miss  = 1'b0;
        store      = 1'b0;
        fill_done  = 1'b0;
        wt_done    = 1'b0;
        flush_en   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        core_ready = 1'b0;
        unique case (state)
            IDLE: begin
                flush_en  = flush;
                accept    = core_req && !flush;
                load_hit  = accept && !core_we && hit;
                load_miss = accept && !core_we && !hit;
                store     = accept && core_we;
            end
            REFILL: begin
                mem_req   = 1'b1;
                fill_done = mem_ack;
            end
            WTHRU: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                wt_done = mem_ack;
            end
            RESP: core_ready = 1'b1;
            default: ;
        endcase
    end

    assign tag_wr = store || fill_done;
    assign wr_idx = store ? core_idx : fill_idx;
    assign wr_tag = store ? core_tag : fill_tag;

    cache_tag_ram #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TW)
    ) u_tag_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (core_idx),
        .rd_tag (core_tag),
        .hit    (hit),
        .wr_en  (tag_wr),
        .wr_idx (wr_idx),
        .wr_tag (wr_tag),
        .flush  (flush_en)
    );

    always_ff @(posedge clk) begin
        if (store) begin
            data_mem[core_idx] <= core_wdata;
        end else if (fill_done) begin
            data_mem[fill_idx] <= mem_rdata;
        end
    end

    // mem_addr doubles as the captured request address for the refill write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
        end else begin
            if (accept && !load_hit) begin
                mem_addr <= core_addr;
            end
            if (store) begin
                mem_wdata <= core_wdata;
            end
            if (load_hit) begin
                core_rdata <= data_mem[core_idx];
            end else if (fill_done) begin
                core_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (load_hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (load_miss && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

endmodule
